// File: rtl/ece385_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ece385_audio_pkg
// Brief    : Shared constants and types for the audio capture PIO:
//            register addresses, STATUS bit positions and the sample type.
// Revision : 1.0 - initial release
// ============================================================================
package ece385_audio_pkg;

    // Register addresses
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_THRESH = 2'd3;

    // STATUS bit positions
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_LEVEL_LSB = 8;

    // One stereo sample: {left[15:0], right[15:0]}
    typedef logic [31:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/ece385_audio_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ece385_audio_fifo
// Brief    : Synchronous FIFO of sample words with level tracking, full /
//            empty flags and a one-cycle overflow pulse for dropped pushes.
//            A pop frees a slot in the same cycle, so a push against a full
//            FIFO succeeds when a pop accompanies it.
// Revision : 1.0 - initial release
// ============================================================================
module ece385_audio_fifo
    import ece385_audio_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  sample_t       din,
    output sample_t       dout,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    sample_t          r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Flags and accepted-operation qualifiers
    always_comb begin
        full      = (r_level == FULL_LEVEL);
        empty     = (r_level == '0);
        w_pop_ok  = pop & ~empty;
        w_push_ok = push & (~full | w_pop_ok);
        overflow  = push & full & ~w_pop_ok;
        level     = r_level;
        dout      = r_mem[r_rd_ptr];
    end

    // Pointer and level bookkeeping; reset flushes all buffered words
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sample storage; no write while reset is held so a flushed push leaves no trace
    always_ff @(posedge clk) begin
        if (reset_n && w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ece385_audio_in_pio.sv
`default_nettype none
// ============================================================================
// Module   : ece385_audio_in_pio
// Brief    : Avalon-MM slave buffering captured audio samples for the CPU.
//            DATA pops the FIFO head, STATUS reports empty/full/overflow and
//            level, IRQ_MASK and THRESH drive a registered level interrupt.
//            Optional macro ECE385_AUDIO_IN_SYNC_EN inserts a two-flop
//            synchronizer with rising-edge detect on in_valid.
// Revision : 1.0 - initial release
// ============================================================================
module ece385_audio_in_pio
    import ece385_audio_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   address,
    input  logic         chipselect,
    input  logic         read_n,
    input  logic         write_n,
    input  logic [31:0]  writedata,
    output logic [31:0]  readdata,
    input  logic [31:0]  in_port,
    input  logic         in_valid,
    output logic         irq
);

    sample_t        w_push_data;
    logic           w_push;
    logic           w_pop;
    logic           w_wr_en;
    sample_t        w_head;
    logic [AW:0]    w_level;
    logic           w_full;
    logic           w_empty;
    logic           w_ovf_evt;
    logic [31:0]    w_status;
    logic           w_unused;

    logic           r_ovf;
    logic [1:0]     r_mask;
    logic [AW:0]    r_thresh;
    logic           r_irq;

`ifdef ECE385_AUDIO_IN_SYNC_EN
    sample_t        r_data_s1;
    sample_t        r_data_s2;
    logic           r_valid_s1;
    logic           r_valid_s2;
    logic           r_valid_s3;

    // Two-flop synchronizer plus one extra stage for rising-edge detect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data_s1  <= '0;
            r_data_s2  <= '0;
            r_valid_s1 <= 1'b0;
            r_valid_s2 <= 1'b0;
            r_valid_s3 <= 1'b0;
        end else begin
            r_data_s1  <= in_port;
            r_data_s2  <= r_data_s1;
            r_valid_s1 <= in_valid;
            r_valid_s2 <= r_valid_s1;
            r_valid_s3 <= r_valid_s2;
        end
    end

    assign w_push      = r_valid_s2 & ~r_valid_s3;
    assign w_push_data = r_data_s2;
`else
    assign w_push      = in_valid;
    assign w_push_data = in_port;
`endif

    assign w_pop    = chipselect & ~read_n & (address == ADDR_DATA);
    assign w_wr_en  = chipselect & ~write_n;
    // Write data bits outside the implemented fields are intentionally ignored
    assign w_unused = &{1'b0, writedata};

    ece385_audio_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (w_push),
        .pop      (w_pop),
        .din      (w_push_data),
        .dout     (w_head),
        .level    (w_level),
        .full     (w_full),
        .empty    (w_empty),
        .overflow (w_ovf_evt)
    );

    // STATUS word assembly; unlisted bits read as zero
    always_comb begin
        w_status                              = '0;
        w_status[ST_EMPTY]                    = w_empty;
        w_status[ST_FULL]                     = w_full;
        w_status[ST_OVF]                      = r_ovf;
        w_status[ST_LEVEL_LSB+AW:ST_LEVEL_LSB] = w_level;
    end

    // Zero-wait-state read mux; an empty FIFO reads back as zero
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = w_empty ? 32'd0 : w_head;
            ADDR_STATUS: readdata = w_status;
            ADDR_MASK:   readdata = {30'd0, r_mask};
            ADDR_THRESH: readdata = {{(31-AW){1'b0}}, r_thresh};
            default:     readdata = '0;
        endcase
    end

    // Control registers and sticky overflow; a new overflow beats a clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ovf    <= 1'b0;
            r_mask   <= '0;
            r_thresh <= (AW+1)'(1);
        end else begin
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (w_wr_en && (address == ADDR_STATUS) && writedata[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_en && (address == ADDR_MASK))   r_mask   <= writedata[1:0];
            if (w_wr_en && (address == ADDR_THRESH)) r_thresh <= writedata[AW:0];
        end
    end

    // Registered interrupt, lagging its cause by one cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_mask[0] & (w_level >= r_thresh) & (r_thresh != '0))
                   | (r_mask[1] & r_ovf);
        end
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_ece385_audio_in_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_ece385_audio_in_pio
// Brief    : Directed self-checking bench for the audio capture PIO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ece385_audio_in_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] in_port;
    logic        in_valid;
    logic        irq;

    int n_vec  = 0;
    int n_fail = 0;

    ece385_audio_in_pio #(.DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .in_valid   (in_valid),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        in_valid = 1'b1;
        in_port  = w;
        cycle();
        in_valid = 1'b0;
    endtask

    // Read a register, check the combinational value, then complete the access
    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        #1;
        chk(tag, readdata, exp);
        cycle();
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1;
        write_n = 1'b1; writedata = '0; in_port = '0; in_valid = 1'b0;
        cycle(); cycle();
        reset_n = 1'b1;

        // Reset state
        rd(2'd0, 32'h0, "rst_data");
        rd(2'd1, 32'h1, "rst_status");
        rd(2'd2, 32'h0, "rst_mask");
        rd(2'd3, 32'h1, "rst_thresh");
        chk("rst_irq", {31'd0, irq}, 32'h0);

        // Ordering and level
        push(32'h12345678);
        push(32'hCAFEF00D);
        rd(2'd1, 32'h00000200, "lvl2");
        rd(2'd0, 32'h12345678, "data0");
        rd(2'd1, 32'h00000100, "lvl1");
        rd(2'd0, 32'hCAFEF00D, "data1");
        rd(2'd1, 32'h00000001, "lvl0");

        // Pop while empty: no change
        rd(2'd0, 32'h0, "pop_empty");
        rd(2'd1, 32'h00000001, "pop_empty_st");

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) push(i);
        rd(2'd1, 32'h00001002, "full");
        push(32'h0000DEAD);
        rd(2'd1, 32'h00001006, "full_ovf");
        for (int i = 0; i < 16; i++) rd(2'd0, i, $sformatf("drain%0d", i));
        rd(2'd1, 32'h00000005, "drained_ovf");
        rd(2'd0, 32'h0, "dead_absent");
        wr(2'd1, 32'h4);
        rd(2'd1, 32'h00000001, "ovf_clr");

        // Push and pop together while full
        for (int i = 0; i < 16; i++) push(32'h100 + i);
        in_valid   = 1'b1;
        in_port    = 32'h0000AAAA;
        rd(2'd0, 32'h100, "pp_head");
        in_valid   = 1'b0;
        rd(2'd1, 32'h00001002, "pp_status");
        for (int i = 1; i < 16; i++) rd(2'd0, 32'h100 + i, $sformatf("pp_drain%0d", i));
        rd(2'd0, 32'h0000AAAA, "pp_last");
        rd(2'd1, 32'h00000001, "pp_empty");

        // Threshold interrupt
        wr(2'd2, 32'h1);
        wr(2'd3, 32'h4);
        rd(2'd2, 32'h1, "mask_rb");
        rd(2'd3, 32'h4, "thresh_rb");
        push(32'h1); push(32'h2); push(32'h3);
        cycle();
        chk("irq_lvl3", {31'd0, irq}, 32'h0);
        push(32'h4);
        chk("irq_lag", {31'd0, irq}, 32'h0);
        cycle();
        chk("irq_lvl4", {31'd0, irq}, 32'h1);
        rd(2'd0, 32'h1, "irq_pop");
        chk("irq_pop_lag", {31'd0, irq}, 32'h1);
        cycle();
        chk("irq_lvl3b", {31'd0, irq}, 32'h0);

        // Reset mid-operation with a push in the same cycle
        push(32'h5); push(32'h6);
        cycle();
        chk("irq_lvl5", {31'd0, irq}, 32'h1);
        rd(2'd1, 32'h00000500, "pre_rst_lvl");
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_port  = 32'h77777777;
        cycle();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        chk("rst2_irq", {31'd0, irq}, 32'h0);
        rd(2'd1, 32'h00000001, "rst2_status");
        rd(2'd0, 32'h0, "rst2_data");
        rd(2'd2, 32'h0, "rst2_mask");

        // Overflow interrupt and clear
        wr(2'd2, 32'h2);
        for (int i = 0; i < 17; i++) push(32'h200 + i);
        cycle();
        chk("irq_ovf", {31'd0, irq}, 32'h1);
        wr(2'd1, 32'h4);
        cycle();
        chk("irq_ovf_clr", {31'd0, irq}, 32'h0);
        rd(2'd1, 32'h00001002, "ovf_clr_st");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
